fft_bitrev_frame_buffer: RTL

//  Parametrised front end for the FFT_Base2 generation of cores. Decimates an I/Q sample

---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_dp_ram.sv | 29 ++
 rtl/fft_bitrev_frame_buffer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared helpers and constants for the FFT bit-reversal frame buffer
package fft_pkg;

    // Complex samples are stored as {I, Q}
    localparam int CPLX_PARTS = 2;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_LOAD   = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int cplx_width(input int data_width);
        return CPLX_PARTS * data_width;
    endfunction

    // Reverse the low 'bits' bits of value; upper bits of the result are zero
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int bits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < bits; i++) r[i] = value[bits-1-i];
        return r;
    endfunction

endpackage

// File: rtl/fft_dp_ram.sv
// rtl/fft_dp_ram.sv - ping-pong sample RAM, one write port and one registered read port
module fft_dp_ram #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Storage array: no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register: cleared on reset so the sample outputs start at zero
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_bitrev_frame_buffer.sv
// rtl/fft_bitrev_frame_buffer.sv - decimating ping-pong frame buffer with bit-reversed readout
module fft_bitrev_frame_buffer
    import fft_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DECIM      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    input  logic                  bitrev_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] i_out,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic [clog2(N)-1:0]   out_index,
    output logic                  out_last,
    output logic                  overflow,
    output logic                  overflow_seen
);

    localparam int AW = clog2(N);
    localparam int CW = cplx_width(DATA_WIDTH);
    localparam int DCW = (DECIM > 1) ? clog2(DECIM) : 1;

    logic [DCW-1:0] decim_cnt;
    logic           keep;
    logic [AW-1:0]  wr_cnt;
    logic           wr_bank;
    logic [1:0]     full;
    logic [1:0]     full_set;
    logic [1:0]     free_now;
    logic           wr_blocked;
    logic           wr_en;
    logic           wr_done;
    logic           drop;

    rd_state_e      state, state_nxt;
    logic           rd_bank;
    logic           rd_bitrev;
    logic [AW-1:0]  rd_cnt;
    logic [AW-1:0]  rd_addr;
    logic           rd_sel;
    logic           rd_en;
    logic           rd_at_end;
    logic           handshake;
    logic [CW-1:0]  rd_data;

    // Write side waits by pointing at a bank that is still full; a bank freed
    // by the reader in this very cycle already counts as available.
    always_comb begin
        keep       = enable && in_valid && (decim_cnt == '0);
        wr_blocked = full[wr_bank] && !free_now[wr_bank];
        wr_en      = keep && !wr_blocked;
        drop       = keep && wr_blocked;
        wr_done    = wr_en && (wr_cnt == AW'(N - 1));
        full_set   = '0;
        if (wr_done) full_set[wr_bank] = 1'b1;
    end

    // Decimator: keep the first of every DECIM accepted samples
    always_ff @(posedge clk) begin
        if (rst || !enable)
            decim_cnt <= '0;
        else if (in_valid)
            decim_cnt <= (decim_cnt == DCW'(DECIM - 1)) ? '0 : decim_cnt + DCW'(1);
    end

    // Write pointer: a completed frame hands over to the other bank immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (!enable) begin
            wr_cnt <= '0;
        end else if (wr_done) begin
            wr_cnt  <= '0;
            wr_bank <= ~wr_bank;
        end else if (wr_en) begin
            wr_cnt <= wr_cnt + AW'(1);
        end
    end

    // Bank-full flags: set by the writer on the last address, cleared by the reader on the last handshake
    always_ff @(posedge clk) begin
        if (rst) full <= '0;
        else     full <= (full & ~free_now) | full_set;
    end

    // Overflow pulse per dropped sample plus its sticky copy
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow      <= 1'b0;
            overflow_seen <= 1'b0;
        end else begin
            overflow      <= drop;
            overflow_seen <= overflow_seen | drop;
        end
    end

    // When both banks are full the write pointer sits on the older one
    always_comb begin
        rd_sel  = full[wr_bank] ? wr_bank : ~wr_bank;
        rd_addr = rd_bitrev ? AW'(bitrev(32'(rd_cnt), AW)) : rd_cnt;
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= RD_IDLE;
        else     state <= state_nxt;
    end

    // Read FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE:   if (|full) state_nxt = RD_LOAD;
            RD_LOAD:   state_nxt = RD_STREAM;
            RD_STREAM: if (out_ready) state_nxt = rd_at_end ? RD_IDLE : RD_LOAD;
            default:   state_nxt = RD_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        rd_at_end = (rd_cnt == AW'(N - 1));
        out_valid = (state == RD_STREAM);
        out_last  = out_valid && rd_at_end;
        rd_en     = (state == RD_LOAD);
        handshake = out_valid && out_ready;
        free_now  = '0;
        if (handshake && rd_at_end) free_now[rd_bank] = 1'b1;
    end

    // Read datapath: bank/order latched per frame, index follows the RAM address
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank   <= 1'b0;
            rd_bitrev <= 1'b0;
            rd_cnt    <= '0;
            out_index <= '0;
        end else begin
            case (state)
                RD_IDLE: begin
                    if (|full) begin
                        rd_bank   <= rd_sel;
                        rd_bitrev <= bitrev_en;
                        rd_cnt    <= '0;
                    end
                end
                RD_LOAD:   out_index <= rd_addr;
                RD_STREAM: if (handshake && !rd_at_end) rd_cnt <= rd_cnt + AW'(1);
                default: ;
            endcase
        end
    end

    fft_dp_ram #(
        .AW (AW + 1),
        .DW (CW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr ({wr_bank, wr_cnt}),
        .wdata ({i_in, q_in}),
        .re    (rd_en),
        .raddr ({rd_bank, rd_addr}),
        .rdata (rd_data)
    );

    assign i_out = rd_data[CW-1:DATA_WIDTH];
    assign q_out = rd_data[DATA_WIDTH-1:0];

endmodule
